// File: rtl/classifier_seq_ctrl.sv
// classifier_seq_ctrl: walks classes/features, issuing reads and datapath strobes for the MAC/argmax classifier.
module classifier_seq_ctrl #(
  parameter int N_FEAT      = 16,
  parameter int N_CLASS     = 8,
  parameter int CLASS_BITS  = 3,
  parameter int FEAT_BITS   = $clog2(N_FEAT),
  parameter int W_ADDR_BITS = $clog2(N_FEAT * N_CLASS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   dp_clear,
  output logic                   rd_en,
  output logic [FEAT_BITS-1:0]   feat_addr,
  output logic [W_ADDR_BITS-1:0] w_addr,
  output logic                   new_feat,
  output logic                   new_class,
  output logic [CLASS_BITS-1:0]  class_id
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CLOSE, FINISH} state_t;
  localparam logic [FEAT_BITS-1:0]  F_LAST = FEAT_BITS'(N_FEAT - 1);
  localparam logic [CLASS_BITS-1:0] C_LAST = CLASS_BITS'(N_CLASS - 1);
  state_t                 state, state_nx;
  logic [FEAT_BITS-1:0]   f, f_nx;
  logic [CLASS_BITS-1:0]  c, c_nx;
  logic [W_ADDR_BITS-1:0] wa, wa_nx;
  assign busy      = state != IDLE;
  assign done      = state == FINISH;
  assign dp_clear  = state == CLEAR;
  assign rd_en     = (state == FEED) && !stall;
  assign new_class = state == CLOSE;
  assign class_id  = new_class ? c : '0;
  assign feat_addr = (state == FEED) ? f : '0;
  assign w_addr    = (state == FEED) ? wa : '0;
  // new_feat trails rd_en by the read latency so it lines up with returned data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      f        <= '0;
      c        <= '0;
      wa       <= '0;
      new_feat <= 1'b0;
    end else begin
      state    <= state_nx;
      f        <= f_nx;
      c        <= c_nx;
      wa       <= wa_nx;
      new_feat <= rd_en;
    end
  end
  always_comb begin
    state_nx = state;
    f_nx     = f;
    c_nx     = c;
    wa_nx    = wa;
    case (state)
      IDLE:   state_nx = start ? CLEAR : IDLE;
      CLEAR: begin
        f_nx     = '0;
        c_nx     = '0;
        wa_nx    = '0;
        state_nx = FEED;
      end
      FEED: begin
        if (rd_en) begin
          f_nx     = (f == F_LAST) ? '0 : f + 1'b1;
          wa_nx    = wa + 1'b1;
          state_nx = (f == F_LAST) ? DRAIN : FEED;
        end
      end
      DRAIN:  state_nx = CLOSE;
      CLOSE: begin
        c_nx     = (c == C_LAST) ? c : c + 1'b1;
        f_nx     = '0;
        state_nx = (c == C_LAST) ? FINISH : FEED;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_classifier_seq_ctrl.sv
// tb_classifier_seq_ctrl: expected cycle trace built from class/feature loops, compared every cycle.
module tb_classifier_seq_ctrl;
  localparam int NF = 4, NC = 3, CB = 2, FB = 2, WB = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
  logic busy, done, dp_clear, rd_en, new_feat, new_class;
  logic [CB-1:0] class_id;
  logic [FB-1:0] feat_addr;
  logic [WB-1:0] w_addr;
  classifier_seq_ctrl #(.N_FEAT(NF), .N_CLASS(NC), .CLASS_BITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
    .dp_clear(dp_clear), .rd_en(rd_en), .feat_addr(feat_addr), .w_addr(w_addr),
    .new_feat(new_feat), .new_class(new_class), .class_id(class_id)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic busy, done, clr, rd, nc;
    logic [CB-1:0] cid;
    logic [FB-1:0] fa;
    logic [WB-1:0] wa;
    logic care;
  } ent_t;
  ent_t trace[$];
  bit   st[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  bit   prev_rd = 1'b0;
  function automatic ent_t mk(bit b, bit d, bit clr, bit rd, bit nc, int cid, int fa, int wa, bit care);
    ent_t e;
    e.busy = b; e.done = d; e.clr = clr; e.rd = rd; e.nc = nc;
    e.cid = CB'(cid); e.fa = FB'(fa); e.wa = WB'(wa); e.care = care;
    return e;
  endfunction
  function automatic logic [31:0] view(ent_t e, ent_t m);
    logic [CB-1:0] cid;
    logic [FB-1:0] fa;
    logic [WB-1:0] wa;
    cid = m.nc ? e.cid : '0;
    fa  = m.care ? e.fa : '0;
    wa  = m.care ? e.wa : '0;
    return 32'({e.busy, e.done, e.clr, e.rd, e.nc, cid, fa, wa});
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input bit s_start, input bit s_stall, input ent_t e);
    ent_t o;
    @(posedge clk);
    cyc++;
    #2 start = s_start; stall = s_stall;
    #3;
    o = mk(busy, done, dp_clear, rd_en, new_class, int'(class_id), int'(feat_addr), int'(w_addr), 1'b1);
    chk("outputs", view(o, e), view(e, e));
    chk("new_feat", 32'(new_feat), 32'(prev_rd));
    chk("excl", 32'(new_feat & new_class), 32'd0);
    prev_rd = e.rd;
  endtask
  task automatic idle_cycle(input bit s_start);
    step(s_start, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  function automatic bit want_stall(int mode, int c, int f, int k);
    if (mode == 1) return (c == 1) && (f == 2) && (k < 3);
    if (mode == 2) return (k < 3) && ($urandom_range(0, 2) == 0);
    return 1'b0;
  endfunction
  function automatic void push(ent_t e, bit s);
    trace.push_back(e);
    st.push_back(s);
  endfunction
  // one entry per cycle from CLEAR through FINISH; mode 0 no stall, 1 directed, 2 random
  function automatic void build(int mode);
    trace.delete();
    st.delete();
    push(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    for (int c = 0; c < NC; c++) begin
      for (int f = 0; f < NF; f++) begin
        for (int k = 0; want_stall(mode, c, f, k); k++)
          push(mk(1, 0, 0, 0, 0, 0, f, c * NF + f, 1), 1'b1);
        push(mk(1, 0, 0, 1, 0, 0, f, c * NF + f, 1), 1'b0);
      end
      push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
      push(mk(1, 0, 0, 0, 1, c, 0, 0, 0), 1'($urandom_range(0, 1)));
    end
    push(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
  endfunction
  task automatic run(input bit hold, input int abort);
    foreach (trace[i]) begin
      if (i == abort) begin
        @(posedge clk);
        cyc++;
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'({busy, done, dp_clear, rd_en, new_feat, new_class, class_id, feat_addr, w_addr}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        prev_rd = 1'b0;
        return;
      end
      step(hold ? 1'b1 : 1'($urandom_range(0, 1)), st[i], trace[i]);
    end
  endtask
  initial begin
    #3 chk("reset", 32'({busy, done, dp_clear, rd_en, new_feat, new_class, class_id, feat_addr, w_addr}), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle_cycle(0);
    idle_cycle(0);
    build(0); idle_cycle(1); run(0, -1); idle_cycle(0);
    build(1); idle_cycle(1); run(0, -1); idle_cycle(0);
    repeat (3) begin
      build(2); idle_cycle(1); run(0, -1); idle_cycle(0);
    end
    build(0); idle_cycle(1); run(1, -1); idle_cycle(1);
    build(2); run(1, -1); idle_cycle(0);
    build(0); idle_cycle(1); run(0, 1 + (NF + 2) + 2);
    repeat (3) idle_cycle(0);
    build(0); idle_cycle(1); run(0, -1); idle_cycle(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/classifier_seq_ctrl.md
# classifier_seq_ctrl

Sequencer for the int4×int8 MAC/argmax classifier datapath. On `start` it walks every class and every feature. It issues synchronous-read addresses to the feature buffer and weight ROM, and drives the datapath event strobes `new_feat`, `new_class` and `class_id` so each class score is fully accumulated before it is compared. It sits between the layer-level control and the datapath, and reports completion with a one-cycle `done` pulse while `max_class` is valid.

## Interface
- `N_FEAT`, 16, features per class (≥2)
- `N_CLASS`, 8, number of classes (≥2)
- `CLASS_BITS`, 3, width of `class_id`; must satisfy 2^CLASS_BITS ≥ N_CLASS
- `FEAT_BITS`, $clog2(N_FEAT), width of `feat_addr`
- `W_ADDR_BITS`, $clog2(N_FEAT*N_CLASS), width of `w_addr`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous reset, active-high
- `start` in 1: request an inference; sampled only in IDLE
- `stall` in 1: freezes read issue while in FEED
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse; datapath `max_class`/`max_score` valid in this cycle
- `dp_clear` out 1: one-cycle pulse that reinitialises the datapath accumulator and max registers
- `rd_en` out 1: read strobe to the feature buffer and weight ROM (1-cycle read latency)
- `feat_addr` out FEAT_BITS: feature index f
- `w_addr` out W_ADDR_BITS: weight index c*N_FEAT+f, row-major
- `new_feat` out 1: to datapath; accumulate the current x/w
- `new_class` out 1: to datapath; compare, update max, clear accumulator
- `class_id` out CLASS_BITS: current class c; valid when `new_class`=1

## Operation
- State register: IDLE, CLEAR, FEED, DRAIN, CLOSE, FINISH. Counters: f (feature), c (class), wa (running weight address).
- IDLE: all strobes 0. `start`=1 → CLEAR.
- CLEAR: one cycle. `dp_clear`=1; f, c and wa all become 0 → FEED.
- FEED: `rd_en`=!`stall`, `feat_addr`=f, `w_addr`=wa.
  - Each cycle with `rd_en`=1: f++ and wa++.
  - When the read for f=N_FEAT-1 is issued → DRAIN.
  - With `stall`=1: counters and state hold.
- DRAIN: one cycle, `rd_en`=0 → CLOSE.
- CLOSE: one cycle, `new_class`=1, `class_id`=c.
  - If c=N_CLASS-1 → FINISH.
  - Otherwise c++, f=0 (wa continues) → FEED.
- FINISH: one cycle, `done`=1 → IDLE.
- `new_feat` is `rd_en` registered by one cycle, so it aligns with ROM/buffer data. This is independent of state and of `stall`.
- Address generation uses the incrementing wa, not a multiplier. wa reaches N_FEAT*N_CLASS-1 on the final read and never wraps inside a run.
- `new_feat` and `new_class` are never high in the same cycle. DRAIN guarantees the last product is accumulated before CLOSE.
- `stall` is ignored outside FEED. A stall never suppresses an already-issued `new_feat`.
- `start` outside IDLE is ignored. If `start` is held high, runs repeat back-to-back with exactly one IDLE cycle between `done` and the next CLEAR.
- Asserting `rst` at any point, including mid-run:
  - State goes to IDLE and all counters go to 0.
  - All outputs go to 0, including the pending `new_feat`.
  - Behaviour is as after power-up; no partial `done`.

## Timing
- Reset value of every output is 0.
- With `start` sampled at edge k and no stall:
  - CLEAR occupies cycle k+1.
  - Class c occupies N_FEAT+2 cycles.
  - `done` is high in the cycle after edge k+1+N_CLASS*(N_FEAT+2) (145 cycles for the defaults).
- Each stall cycle in FEED adds exactly one cycle of latency.
- `busy` rises in the cycle after the start edge. It falls in the cycle after `done`.
- `new_class` for class c comes exactly 2 cycles after the last `rd_en` of that class (1 for the read latency, 1 for DRAIN).
- All outputs are decoded from registers only. There is no combinational path from `start` or `stall` to outputs, except `rd_en` from `stall` in FEED.

## Test plan
- N_FEAT=4, N_CLASS=3, no stall, single `start` → `dp_clear` at cycle 1; `w_addr` sequence 0..11; 12 `new_feat` pulses; `new_class` with `class_id` 0, 1, 2 at cycles 7, 13, 19; `done` at cycle 20; `busy` cleared in cycle 21.
- Same config with `stall` high for 3 cycles at f=2 of class 1 → `rd_en` low for those 3 cycles; address sequence unchanged; `done` at cycle 23; `new_feat` count still 12.
- Integrated with the datapath: all x=1, weights giving class scores 5, −3, 9 → `max_class`=2 and `max_score`=9 when `done`=1.
- `start` held high continuously → second CLEAR exactly 2 cycles after the first `done`; `start` pulses during a run have no effect.
- Reset asserted mid-FEED of class 1 → all outputs 0 immediately (async); after release, IDLE and no `done`; a new `start` runs a full correct sequence.
- Check on every cycle of every scenario: `new_feat` and `new_class` never both high; `new_feat` equals the previous cycle's `rd_en`.
